// File: rtl/latch_checker_if.sv
// latch_checker_if
// Bundles the signals exchanged between a latch checker and whatever drives
// and observes it. The clock and reset are not part of this bundle.
//
// Ports / members:
//   clear           - synchronous clear of the error reporting
//   d, g            - data and gate as driven to the latch under test
//   q               - output of the latch under test
//   state           - golden model state (0 UNKNOWN, 1 TRANSPARENT, 2 HOLD)
//   err_pulse       - one-cycle pulse per detected mismatch
//   err_sticky      - set on the first mismatch, held until reset/clear
//   err_count       - saturating mismatch count (CW bits)
//   first_err_cycle - cycle-counter value of the first bad q sample (TW bits)
//
// Modports:
//   master - environment side (drives clear/d/g/q, observes results)
//   slave  - checker side
interface latch_checker_if #(
    parameter int CW = 8,
    parameter int TW = 16
);
    logic          clear;
    logic          d;
    logic          g;
    logic          q;
    logic [1:0]    state;
    logic          err_pulse;
    logic          err_sticky;
    logic [CW-1:0] err_count;
    logic [TW-1:0] first_err_cycle;

    modport master (
        output clear, d, g, q,
        input  state, err_pulse, err_sticky, err_count, first_err_cycle
    );

    modport slave (
        input  clear, d, g, q,
        output state, err_pulse, err_sticky, err_count, first_err_cycle
    );
endinterface

// File: rtl/latch_checker.sv
// latch_checker
// Cycle-accurate checker for a gated D latch. Every rising clock edge the
// latch's d, g and q are registered. A golden model runs on the registered
// sample and predicts q; the prediction is delayed LAT cycles and compared
// against the q registered LAT samples later. Mismatches are reported as a
// pulse, a sticky flag, a saturating count and the cycle of the first one.
//
// Parameters:
//   LAT - cycles between a sample and the q sample it is checked against
//   CW  - width of err_count
//   TW  - width of the cycle counter and first_err_cycle
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous active-high reset, clears all state
//   bus   - latch_checker_if slave modport (inputs d/g/q/clear, results)
module latch_checker #(
    parameter int LAT = 0,
    parameter int CW  = 8,
    parameter int TW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    latch_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_UNKNOWN     = 2'd0,
        ST_TRANSPARENT = 2'd1,
        ST_HOLD        = 2'd2
    } model_state_t;

    logic          d_r;
    logic          g_r;
    logic          q_r;
    logic [TW-1:0] cycle_cnt;
    logic [TW-1:0] sample_cycle;

    model_state_t  state_r;
    logic          hold_val;

    logic          exp_valid;
    logic          exp_val;
    logic          chk_valid;
    logic          chk_val;
    logic          mismatch;

    logic          err_pulse_r;
    logic          err_sticky_r;
    logic [CW-1:0] err_count_r;
    logic [TW-1:0] first_err_r;

    // Input registration. sample_cycle tags the registered q with the
    // counter value it was captured at, so a later mismatch can report it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_r          <= 1'b0;
            g_r          <= 1'b0;
            q_r          <= 1'b0;
            cycle_cnt    <= '0;
            sample_cycle <= '0;
        end else begin
            d_r          <= bus.d;
            g_r          <= bus.g;
            q_r          <= bus.q;
            cycle_cnt    <= cycle_cnt + TW'(1);
            sample_cycle <= cycle_cnt;
        end
    end

    // Prediction for the registered sample. Until the gate has been seen
    // high once, the latch content is unknown and nothing is predicted.
    always_comb begin
        exp_valid = g_r || (state_r != ST_UNKNOWN);
        exp_val   = g_r ? d_r : hold_val;
    end

    // Golden model FSM. The hold value only follows d while the gate is
    // high, so a d change in the same sample as g falling is not captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_UNKNOWN;
            hold_val <= 1'b0;
        end else begin
            if (g_r) begin
                hold_val <= d_r;
            end
            case (state_r)
                ST_UNKNOWN:     state_r <= g_r ? ST_TRANSPARENT : ST_UNKNOWN;
                ST_TRANSPARENT: state_r <= g_r ? ST_TRANSPARENT : ST_HOLD;
                ST_HOLD:        state_r <= g_r ? ST_TRANSPARENT : ST_HOLD;
                default:        state_r <= ST_UNKNOWN;
            endcase
        end
    end

    // Delay line aligning each prediction with the q sample LAT cycles
    // later. Valid bits are flushed by reset so no stale entry is checked.
    generate
        if (LAT == 0) begin : g_no_delay
            assign chk_valid = exp_valid;
            assign chk_val   = exp_val;
        end else begin : g_delay
            logic [LAT-1:0] pipe_v;
            logic [LAT-1:0] pipe_d;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pipe_v <= '0;
                    pipe_d <= '0;
                end else begin
                    pipe_v[0] <= exp_valid;
                    pipe_d[0] <= exp_val;
                    for (int i = 1; i < LAT; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                        pipe_d[i] <= pipe_d[i-1];
                    end
                end
            end

            assign chk_valid = pipe_v[LAT-1];
            assign chk_val   = pipe_d[LAT-1];
        end
    endgenerate

    // Case inequality so an X/Z on q in simulation counts as a mismatch.
    assign mismatch = chk_valid && (q_r !== chk_val);

    // Error reporting. clear takes priority over a mismatch on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse_r  <= 1'b0;
            err_sticky_r <= 1'b0;
            err_count_r  <= '0;
            first_err_r  <= '0;
        end else if (bus.clear) begin
            err_pulse_r  <= 1'b0;
            err_sticky_r <= 1'b0;
            err_count_r  <= '0;
            first_err_r  <= '0;
        end else begin
            err_pulse_r <= mismatch;
            if (mismatch) begin
                if (err_count_r != '1) begin
                    err_count_r <= err_count_r + CW'(1);
                end
                if (!err_sticky_r) begin
                    err_sticky_r <= 1'b1;
                    first_err_r  <= sample_cycle;
                end
            end
        end
    end

    assign bus.state           = state_r;
    assign bus.err_pulse       = err_pulse_r;
    assign bus.err_sticky      = err_sticky_r;
    assign bus.err_count       = err_count_r;
    assign bus.first_err_cycle = first_err_r;

endmodule

// File: tb/tb_latch_checker.sv
// tb_latch_checker
// Drives two checkers side by side from the same d/g stream: dut_a with no
// latency and a 4-bit error counter, dut_b with three cycles of latency and
// an 8-bit counter. Each gets its own q. A reference model keeps the whole
// sample history since reset and derives the expected latch content as the
// d of the latest sample whose gate was high.
module tb_latch_checker;

    localparam int TW    = 16;
    localparam int LAT_A = 0;
    localparam int CW_A  = 4;
    localparam int LAT_B = 3;
    localparam int CW_B  = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    latch_checker_if #(.CW(CW_A), .TW(TW)) ifa ();
    latch_checker_if #(.CW(CW_B), .TW(TW)) ifb ();

    latch_checker #(.LAT(LAT_A), .CW(CW_A), .TW(TW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    latch_checker #(.LAT(LAT_B), .CW(CW_B), .TW(TW)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    // Sample history since the last reset, index = sample number.
    logic d_h[$];
    logic g_h[$];
    logic qa_h[$];
    logic qb_h[$];
    logic clr_h[$];

    int lat_of[2]  = '{LAT_A, LAT_B};
    int cmax_of[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

    int m_state;
    int m_pulse[2];
    int m_sticky[2];
    int m_count[2];
    int m_first[2];

    int checks_total  = 0;
    int checks_passed = 0;

    // Expected latch content after sample k: d of the latest gate-high sample.
    function automatic void exp_at(input int k, output logic valid, output logic val);
        valid = 1'b0;
        val   = 1'b0;
        for (int j = k; j >= 0 && !valid; j--) begin
            if (g_h[j]) begin
                valid = 1'b1;
                val   = d_h[j];
            end
        end
    endfunction

    // q that an ideal latch delayed by 'delay' cycles would show for the
    // sample just pushed; fallback where the latch content is still unknown.
    function automatic logic ideal_q(input int delay, input logic fallback);
        logic v;
        logic e;
        int   k;
        k = d_h.size() - 1 - delay;
        if (k < 0) return fallback;
        exp_at(k, v, e);
        return v ? e : fallback;
    endfunction

    task automatic model_reset();
        d_h.delete();
        g_h.delete();
        qa_h.delete();
        qb_h.delete();
        clr_h.delete();
        m_state = 0;
        for (int i = 0; i < 2; i++) begin
            m_pulse[i]  = 0;
            m_sticky[i] = 0;
            m_count[i]  = 0;
            m_first[i]  = 0;
        end
    endtask

    // Expected outputs after the edge that captured sample s: the q of
    // sample s-1 is judged against the latch content of sample s-1-LAT.
    task automatic model_edge();
        int   s;
        logic v;
        logic e;
        s = d_h.size() - 1;
        for (int i = 0; i < 2; i++) begin
            logic mis;
            logic qv;
            int   k;
            mis = 1'b0;
            if (s >= 1) begin
                k = s - 1 - lat_of[i];
                if (k >= 0) begin
                    exp_at(k, v, e);
                    qv = (i == 0) ? qa_h[s-1] : qb_h[s-1];
                    if (v && (qv !== e)) mis = 1'b1;
                end
            end
            if (clr_h[s]) begin
                m_pulse[i]  = 0;
                m_sticky[i] = 0;
                m_count[i]  = 0;
                m_first[i]  = 0;
            end else if (mis) begin
                m_pulse[i] = 1;
                if (m_count[i] < cmax_of[i]) m_count[i]++;
                if (m_sticky[i] == 0) begin
                    m_sticky[i] = 1;
                    m_first[i]  = s - 1;
                end
            end else begin
                m_pulse[i] = 0;
            end
        end
        m_state = 0;
        if (s >= 1) begin
            exp_at(s - 1, v, e);
            if (v) m_state = g_h[s-1] ? 1 : 2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks_total++;
        assert (obs === expv) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_output();
        check("a.state",           32'(ifa.state),           m_state);
        check("a.err_pulse",       32'(ifa.err_pulse),       m_pulse[0]);
        check("a.err_sticky",      32'(ifa.err_sticky),      m_sticky[0]);
        check("a.err_count",       32'(ifa.err_count),       m_count[0]);
        check("a.first_err_cycle", 32'(ifa.first_err_cycle), m_first[0]);
        check("b.state",           32'(ifb.state),           m_state);
        check("b.err_pulse",       32'(ifb.err_pulse),       m_pulse[1]);
        check("b.err_sticky",      32'(ifb.err_sticky),      m_sticky[1]);
        check("b.err_count",       32'(ifb.err_count),       m_count[1]);
        check("b.first_err_cycle", 32'(ifb.first_err_cycle), m_first[1]);
    endtask

    // One sample: qa/qb either follow an ideal latch delayed by the given
    // number of cycles (delay >= 0) or take the given value (delay < 0).
    task automatic apply_stimulus(input logic dv, input logic gv,
                                  input int qa_delay, input logic qa_val,
                                  input int qb_delay, input logic qb_val,
                                  input logic clr);
        logic qa;
        logic qb;
        d_h.push_back(dv);
        g_h.push_back(gv);
        clr_h.push_back(clr);
        qa = (qa_delay < 0) ? qa_val : ideal_q(qa_delay, qa_val);
        qb = (qb_delay < 0) ? qb_val : ideal_q(qb_delay, qb_val);
        qa_h.push_back(qa);
        qb_h.push_back(qb);
        ifa.d = dv;  ifa.g = gv;  ifa.q = qa;  ifa.clear = clr;
        ifb.d = dv;  ifb.g = gv;  ifb.q = qb;  ifb.clear = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifa.d = 1'b0;  ifa.g = 1'b0;  ifa.q = 1'b0;  ifa.clear = 1'b0;
        ifb.d = 1'b0;  ifb.g = 1'b0;  ifb.q = 1'b0;  ifb.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_output();
        #1;
        reset = 1'b0;
    endtask

    // Reset pulse fully between two edges; called right after an edge.
    task automatic pulse_reset();
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_output();
        #1;
        reset = 1'b0;
    endtask

    logic [1:0] walk_dg[10] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11,
                                2'b10, 2'b00, 2'b01, 2'b11, 2'b01};
    int walk_state[10] = '{0, 1, 2, 2, 1, 2, 2, 1, 1, 1};

    initial begin
        logic dv;
        logic gv;

        $display("[TB] ideal latch walk");
        do_reset();
        for (int i = 0; i < 10; i++) begin
            repeat (5) apply_stimulus(walk_dg[i][1], walk_dg[i][0], 0, 1'b0, LAT_B, 1'b0, 1'b0);
            check("walk.state", 32'(ifa.state), walk_state[i]);
        end
        check("walk.err_count", 32'(ifa.err_count), 0);
        check("walk.err_sticky", 32'(ifa.err_sticky), 0);

        $display("[TB] hold violation");
        do_reset();
        repeat (3) apply_stimulus(1'b1, 1'b1, 0, 1'b0, LAT_B, 1'b0, 1'b0);
        repeat (8) begin
            apply_stimulus(1'b0, 1'b0, -1, 1'b0, LAT_B, 1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 1'b1, 0, 1'b0, LAT_B, 1'b0, 1'b0);
        check("hold.err_count", 32'(ifa.err_count), 8);
        check("hold.first_err_cycle", 32'(ifa.first_err_cycle), 3);
        check("hold.err_sticky", 32'(ifa.err_sticky), 1);

        $display("[TB] pre-first-enable");
        do_reset();
        repeat (20) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, -1, 1'bx, -1, 1'bx, 1'b0);
        check("pre.state", 32'(ifa.state), 0);
        check("pre.err_count_a", 32'(ifa.err_count), 0);
        check("pre.err_count_b", 32'(ifb.err_count), 0);
        repeat (5) apply_stimulus(1'($urandom_range(0, 1)), 1'b1, 0, 1'b0, LAT_B, 1'b0, 1'b0);
        check("pre.state_after_g", 32'(ifa.state), 1);

        $display("[TB] latency");
        do_reset();
        repeat (60) begin
            dv = 1'($urandom_range(0, 1));
            gv = ($urandom_range(0, 3) != 0);
            apply_stimulus(dv, gv, 0, 1'b0, LAT_B, 1'b0, 1'b0);
        end
        check("lat.err_count_b", 32'(ifb.err_count), 0);
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(1'((i / 4) % 2), 1'b1, 0, 1'b0, 2, 1'b0, 1'b0);
        end
        check("lat.short_delay_seen", 32'(ifb.err_count != 0), 1);

        $display("[TB] saturation and clear");
        do_reset();
        for (int i = 0; i < 20; i++) begin
            dv = 1'(i % 2);
            apply_stimulus(dv, 1'b1, -1, ~dv, LAT_B, 1'b0, 1'b0);
        end
        check("sat.err_count", 32'(ifa.err_count), 15);
        check("sat.first_err_cycle", 32'(ifa.first_err_cycle), 0);
        apply_stimulus(1'b1, 1'b1, -1, 1'b0, LAT_B, 1'b0, 1'b1);
        check("clr.err_pulse", 32'(ifa.err_pulse), 0);
        check("clr.err_sticky", 32'(ifa.err_sticky), 0);
        check("clr.err_count", 32'(ifa.err_count), 0);
        check("clr.first_err_cycle", 32'(ifa.first_err_cycle), 0);
        check("clr.state", 32'(ifa.state), 1);
        repeat (3) apply_stimulus(1'b0, 1'b1, -1, 1'b1, LAT_B, 1'b0, 1'b0);

        $display("[TB] async reset mid-hold");
        do_reset();
        repeat (4) apply_stimulus(1'b1, 1'b1, 0, 1'b0, LAT_B, 1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b0, 1'b0, 0, 1'b0, LAT_B, 1'b0, 1'b0);
        check("rst.state_before", 32'(ifa.state), 2);
        pulse_reset();
        repeat (6) apply_stimulus(1'b0, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0);
        check("rst.err_count_b", 32'(ifb.err_count), 0);
        check("rst.err_sticky_b", 32'(ifb.err_sticky), 0);
        check("rst.state_after", 32'(ifa.state), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/latch_checker.md
# latch_checker

Synchronous hardware checker for a gated D latch under test. Each rising edge of the system clock it samples the latch's data input `d`, gate `g` and output `q`, and runs a cycle-accurate golden model (transparent while `g`=1, hold while `g`=0). It compares the model against `q` after a configurable latency and reports mismatches through a pulse, a sticky flag, a saturating counter and a first-error timestamp. It sits beside a latch instance in lab benches and on-board self-test wrappers.

## Interface
- `LAT`, 0: cycles between a sample and the `q` sample it is checked against (0..7).
- `CW`, 8: width of `err_count`.
- `TW`, 16: width of the cycle counter and `first_err_cycle`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `clear` input 1: synchronous clear of error reporting only (model state kept).
- `d` input 1: latch data input, as driven to the latch.
- `g` input 1: latch gate/enable, as driven to the latch.
- `q` input 1: latch output under test.
- `state` output 2: model state: 0 UNKNOWN, 1 TRANSPARENT, 2 HOLD.
- `err_pulse` output 1: one-cycle pulse per detected mismatch.
- `err_sticky` output 1: set on the first mismatch, held until `reset`/`clear`.
- `err_count` output CW: mismatch count, saturates at all-ones.
- `first_err_cycle` output TW: cycle-counter value at the first mismatch.

## Operation
- Inputs `d`, `g`, `q` are synchronous to `clk` and are registered at every edge (sample k).
- Model FSM, evaluated on the registered sample:
  - UNKNOWN: `g`=1 -> TRANSPARENT, exp=`d`. `g`=0 -> stay; exp invalid.
  - TRANSPARENT: `g`=1 -> stay, exp=`d`. `g`=0 -> HOLD, exp=hold value.
  - HOLD: `g`=1 -> TRANSPARENT, exp=`d`. `g`=0 -> stay, exp=hold value.
- Hold value = `d` from the last sample with `g`=1. `d` changing in the same sample as `g` falling is not captured.
- Each valid exp(k) plus its valid bit travels through a LAT-deep delay line. It is compared with `q` registered at sample k+LAT.
- Any `q` not equal to exp (including X/Z in simulation) is a mismatch. Invalid entries are never checked.
- Free-running cycle counter (TW bits) increments every edge and wraps; it is not affected by `clear`.
- On mismatch:
  - `err_pulse`=1 for one cycle.
  - `err_count`+1, saturating at 2^CW−1.
  - If `err_sticky` was 0, `first_err_cycle` takes the counter value of the checked `q` sample and `err_sticky` is set.
- `clear`:
  - Zeroes `err_pulse`, `err_sticky`, `err_count`, `first_err_cycle` at the next edge.
  - A mismatch detected on that same edge is discarded (clear wins).
  - The FSM, the hold value and the delay line are untouched.
- `reset` mid-run:
  - All outputs are 0 and `state`=UNKNOWN immediately.
  - Delay-line valid bits are flushed, so no stale checks occur after release.

## Timing
- Reset values: `state`=0, `err_pulse`=0, `err_sticky`=0, `err_count`=0, `first_err_cycle`=0; cycle counter 0.
- Input registration: 1 edge. Sample k is captured at edge k.
- `state` reflects sample k after edge k+1.
- Mismatch on check of exp(k) vs `q`(k+LAT): `err_pulse`, `err_count`, `err_sticky` update at edge k+LAT+1.
- Back-to-back mismatches give a continuous high `err_pulse`, and the count increments each cycle.
- The first check after reset release occurs no earlier than the first `g`=1 sample plus LAT.

## Test plan
- LAT=0, ideal latch model on `q`:
  - Stimulus: 10-step sequence (d,g) = 00,01,00,10,11,10,00,01,11,01, each step held 5 cycles.
  - Required: `err_count`=0, `err_sticky`=0.
  - Required: `state` walks 0 -> 1 -> 2 -> 2 -> 1 -> 2 -> 2 -> 1 -> 1 -> 1.
- Hold violation:
  - Stimulus: `g`=1,`d`=1 for 3 cycles; then `g`=0, `d`=0 with `q` forced to follow `d`.
  - Required: mismatch from the first cycle `d`=0 while `g`=0; `err_pulse` high every cycle that persists; `err_count` equals that cycle count.
  - Required: `first_err_cycle` equals the counter value of that first bad sample.
- Pre-first-enable:
  - Stimulus: after reset, `g`=0 and `q`=X for 20 cycles, then `g`=1.
  - Required: no errors while `g`=0; `state`=0 until `g`=1.
- Latency: LAT=3, `q` driven as the model delayed by 3 cycles.
  - Required: `err_count`=0.
  - Same run with a 2-cycle delay on `q` and `d` toggling every 4 cycles while `g`=1: errors are reported.
- Saturation / clear, CW=4:
  - Stimulus: 20 consecutive mismatches.
  - Required: `err_count`=15 and holds; `first_err_cycle` unchanged after the first mismatch.
  - Stimulus: assert `clear` on a mismatch cycle.
  - Required: all error outputs 0 next cycle; `state` unchanged.
- Async reset mid-HOLD:
  - Stimulus: pulse `reset` between edges while `state`=2.
  - Required: outputs zero before the next edge; no error is reported for the in-flight delay-line entries after release.
